// File: rtl/bip_pkg.sv
// Shared opcodes, FSM states, ALU operations and the instruction decoder for the bip_cpu_mc core.
// Logic/shift opcodes exist only when BIP_LOGIC_OPS_EN is defined.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b01010;
`ifdef BIP_LOGIC_OPS_EN
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_OR   = 5'b01110;
    localparam logic [4:0] OP_ORI  = 5'b01111;
    localparam logic [4:0] OP_XOR  = 5'b10000;
    localparam logic [4:0] OP_XORI = 5'b10001;
    localparam logic [4:0] OP_SLL  = 5'b10010;
    localparam logic [4:0] OP_SRL  = 5'b10011;
`endif

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    typedef enum logic [2:0] {
        ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    acc_we;
        logic    mem_rd;
        logic    mem_wr;
    } dec_t;

    // Anything not matched here (branches, HLT, unlisted codes) leaves ACC and memory alone.
    function automatic dec_t decode(input logic [4:0] opc);
        dec_t d;
        d.alu_op = ALU_PASS;
        d.acc_we = 1'b0;
        d.mem_rd = 1'b0;
        d.mem_wr = 1'b0;
        case (opc)
            OP_STO:  d.mem_wr = 1'b1;
            OP_LD:   begin d.mem_rd = 1'b1; d.acc_we = 1'b1; end
            OP_LDI:  d.acc_we = 1'b1;
            OP_ADD:  begin d.alu_op = ALU_ADD; d.mem_rd = 1'b1; d.acc_we = 1'b1; end
            OP_ADDI: begin d.alu_op = ALU_ADD; d.acc_we = 1'b1; end
            OP_SUB:  begin d.alu_op = ALU_SUB; d.mem_rd = 1'b1; d.acc_we = 1'b1; end
            OP_SUBI: begin d.alu_op = ALU_SUB; d.acc_we = 1'b1; end
`ifdef BIP_LOGIC_OPS_EN
            OP_AND:  begin d.alu_op = ALU_AND; d.mem_rd = 1'b1; d.acc_we = 1'b1; end
            OP_ANDI: begin d.alu_op = ALU_AND; d.acc_we = 1'b1; end
            OP_OR:   begin d.alu_op = ALU_OR;  d.mem_rd = 1'b1; d.acc_we = 1'b1; end
            OP_ORI:  begin d.alu_op = ALU_OR;  d.acc_we = 1'b1; end
            OP_XOR:  begin d.alu_op = ALU_XOR; d.mem_rd = 1'b1; d.acc_we = 1'b1; end
            OP_XORI: begin d.alu_op = ALU_XOR; d.acc_we = 1'b1; end
            OP_SLL:  begin d.alu_op = ALU_SLL; d.acc_we = 1'b1; end
            OP_SRL:  begin d.alu_op = ALU_SRL; d.acc_we = 1'b1; end
`endif
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bip_alu.sv
// Combinational accumulator ALU: pass/add/sub, plus logic and shift operations
// when BIP_LOGIC_OPS_EN is defined.
module bip_alu
    import bip_pkg::*;
#(
    parameter int DATA_LENGTH = 16
) (
    input  alu_op_t                op_i,
`ifdef BIP_LOGIC_OPS_EN
    input  logic [3:0]             shamt_i,
`endif
    input  logic [DATA_LENGTH-1:0] acc_i,
    input  logic [DATA_LENGTH-1:0] b_i,
    output logic [DATA_LENGTH-1:0] result_o
);

    always_comb begin
        result_o = b_i;
        case (op_i)
            ALU_ADD: result_o = acc_i + b_i;
            ALU_SUB: result_o = acc_i - b_i;
`ifdef BIP_LOGIC_OPS_EN
            ALU_AND: result_o = acc_i & b_i;
            ALU_OR:  result_o = acc_i | b_i;
            ALU_XOR: result_o = acc_i ^ b_i;
            ALU_SLL: result_o = acc_i << shamt_i;
            ALU_SRL: result_o = acc_i >> shamt_i;
`endif
            default: result_o = b_i;
        endcase
    end

endmodule

// File: rtl/bip_cpu_mc.sv
// Multi-cycle accumulator CPU with wait-state program/data memory handshakes, branches and HALT.
// Define BIP_LOGIC_OPS_EN to add AND/OR/XOR (memory and immediate) and SLL/SRL.
module bip_cpu_mc
    import bip_pkg::*;
#(
    parameter int ADDR_LENGTH        = 11,
    parameter int DATA_LENGTH        = 16,
    parameter int OPCODE_LENGTH      = 5,
    parameter int OPERAND_LENGTH     = 11,
    parameter int INSTRUCTION_LENGTH = 16,
    parameter int COUNT_LENGTH       = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INSTRUCTION_LENGTH-1:0] instruction,
    input  logic                          pm_ready,
    output logic [ADDR_LENGTH-1:0]        addr_to_pm,
    input  logic [DATA_LENGTH-1:0]        data_from_dm,
    input  logic                          dm_ready,
    output logic [DATA_LENGTH-1:0]        data_to_dm,
    output logic [ADDR_LENGTH-1:0]        addr_to_dm,
    output logic                          RdRam,
    output logic                          WrRam,
    output logic                          halted,
    output logic [COUNT_LENGTH-1:0]       retired
);

    state_t                        state_q;
    logic [ADDR_LENGTH-1:0]        pc_q;
    logic [ADDR_LENGTH-1:0]        addr_dm_q;
    logic [DATA_LENGTH-1:0]        acc_q;
    logic [INSTRUCTION_LENGTH-1:0] ir_q;
    logic                          rd_q;
    logic                          wr_q;
    logic                          halted_q;
    logic [COUNT_LENGTH-1:0]       retired_q;

    logic [4:0]                    opc;
    logic [OPERAND_LENGTH-1:0]     operand;
    dec_t                          dec;
    logic [DATA_LENGTH-1:0]        imm_sx;
    logic [DATA_LENGTH-1:0]        alu_b;
    logic [DATA_LENGTH-1:0]        alu_y;
    logic                          br_taken;
    logic [ADDR_LENGTH-1:0]        pc_d;
    logic [COUNT_LENGTH-1:0]       retired_d;

    assign opc     = 5'(ir_q[INSTRUCTION_LENGTH-1 -: OPCODE_LENGTH]);
    assign operand = ir_q[OPERAND_LENGTH-1:0];
    assign dec     = decode(opc);
    assign imm_sx  = DATA_LENGTH'($signed(operand));
    assign alu_b   = dec.mem_rd ? data_from_dm : imm_sx;

    // Only meaningful in EXEC; in MEM the opcode is never a branch so pc_d is PC+1.
    assign br_taken = (opc == OP_JMP)
                    | ((opc == OP_BEQ) && (acc_q == '0))
                    | ((opc == OP_BNE) && (acc_q != '0));
    assign pc_d      = br_taken ? ADDR_LENGTH'(operand) : pc_q + 1'b1;
    assign retired_d = (&retired_q) ? retired_q : retired_q + 1'b1;

    bip_alu #(
        .DATA_LENGTH(DATA_LENGTH)
    ) u_alu (
        .op_i     (dec.alu_op),
`ifdef BIP_LOGIC_OPS_EN
        .shamt_i  (ir_q[3:0]),
`endif
        .acc_i    (acc_q),
        .b_i      (alu_b),
        .result_o (alu_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            addr_dm_q <= '0;
            acc_q     <= '0;
            ir_q      <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (pm_ready) begin
                        ir_q    <= instruction;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (opc == OP_HLT) begin
                        halted_q  <= 1'b1;
                        retired_q <= retired_d;
                        state_q   <= HALT;
                    end else if (dec.mem_rd || dec.mem_wr) begin
                        addr_dm_q <= ADDR_LENGTH'(operand);
                        rd_q      <= dec.mem_rd;
                        wr_q      <= dec.mem_wr;
                        state_q   <= MEM;
                    end else begin
                        if (dec.acc_we) begin
                            acc_q <= alu_y;
                        end
                        pc_q      <= pc_d;
                        retired_q <= retired_d;
                        state_q   <= FETCH;
                    end
                end
                MEM: begin
                    // Request stays asserted and stable until the data memory acknowledges.
                    if (dm_ready) begin
                        if (dec.acc_we) begin
                            acc_q <= alu_y;
                        end
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        pc_q      <= pc_d;
                        retired_q <= retired_d;
                        state_q   <= FETCH;
                    end
                end
                HALT: ;
                default: state_q <= FETCH;
            endcase
        end
    end

    assign addr_to_pm = pc_q;
    assign data_to_dm = acc_q;
    assign addr_to_dm = addr_dm_q;
    assign RdRam      = rd_q;
    assign WrRam      = wr_q;
    assign halted     = halted_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_bip_cpu_mc.sv
// Scoreboard bench for bip_cpu_mc: directed programs push expected memory, halt and reset
// events; monitors compare them as the core produces them. Honours BIP_LOGIC_OPS_EN.
module tb_bip_cpu_mc;
    import bip_pkg::*;

    localparam int K_W = 0, K_R = 1, K_H = 2, K_RST = 3;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instruction;
    logic        pm_ready = 1'b1;
    logic [10:0] addr_to_pm;
    logic [15:0] data_from_dm;
    logic        dm_ready = 1'b0;
    logic [15:0] data_to_dm;
    logic [10:0] addr_to_dm;
    logic        RdRam, WrRam, halted;
    logic [31:0] retired;

    logic [15:0] pm [0:2047];
    logic [15:0] dm [0:2047];
    logic        tb_we = 1'b0;
    logic [10:0] tb_addr = '0;
    logic [15:0] tb_data = '0;
    bit          pm_rand = 1'b0;
    int          dm_wait = 0;
    int          dm_cnt = 0;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          rd_cycles = 0;
    logic [10:0] rd_addr;
    logic [15:0] rd_data;
    logic        halted_prev = 1'b0;
    logic [15:0] exp6;

    bip_cpu_mc dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .pm_ready     (pm_ready),
        .addr_to_pm   (addr_to_pm),
        .data_from_dm (data_from_dm),
        .dm_ready     (dm_ready),
        .data_to_dm   (data_to_dm),
        .addr_to_dm   (addr_to_dm),
        .RdRam        (RdRam),
        .WrRam        (WrRam),
        .halted       (halted),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    assign instruction  = pm[addr_to_pm];
    assign data_from_dm = dm[addr_to_dm];

    always @(posedge clk) begin
        if (WrRam && dm_ready) dm[addr_to_dm] <= data_to_dm;
        else if (tb_we)        dm[tb_addr] <= tb_data;
    end

    // Memory wait-state generator: dm acknowledges after dm_wait full request cycles.
    always @(posedge clk) begin
        #1;
        pm_ready = pm_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (RdRam || WrRam) begin
            if (dm_cnt == dm_wait) dm_ready = 1'b1;
            else begin dm_ready = 1'b0; dm_cnt++; end
        end else begin
            dm_ready = 1'b0;
            dm_cnt = 0;
        end
    end

    function automatic logic [15:0] enc(input logic [4:0] o, input logic [10:0] v);
        return {o, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        exp_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c;
        sb.push_back(e);
    endtask

    task automatic pop_exp(input int kind, output exp_t e, output bit ok);
        checks++;
        ok = 1'b0;
        e.kind = -1; e.a = '0; e.b = '0; e.c = '0;
        if (sb.size() == 0 || sb[0].kind != kind) begin
            errors++;
            $display("FAIL event_order actual_kind=%0d required_kind=%0d", kind,
                     (sb.size() == 0) ? -1 : sb[0].kind);
        end else begin
            e = sb.pop_front();
            ok = 1'b1;
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        bit   ok;
        if (reset) begin
            rd_cycles = 0;
            halted_prev = 1'b0;
        end else begin
            if (WrRam && dm_ready) begin
                $display("txn W addr=%h data=%h", addr_to_dm, data_to_dm);
                pop_exp(K_W, e, ok);
                if (ok) begin
                    check("wr_addr", 32'(addr_to_dm), e.a);
                    check("wr_data", 32'(data_to_dm), e.b);
                end
            end
            if (RdRam) begin
                rd_cycles++;
                rd_addr = addr_to_dm;
                rd_data = data_from_dm;
            end else if (rd_cycles != 0) begin
                $display("txn R addr=%h data=%h cycles=%0d", rd_addr, rd_data, rd_cycles);
                pop_exp(K_R, e, ok);
                if (ok) begin
                    check("rd_addr", 32'(rd_addr), e.a);
                    check("rd_data", 32'(rd_data), e.b);
                    check("rd_cycles", 32'(rd_cycles), e.c);
                end
                rd_cycles = 0;
            end
            if (halted && !halted_prev) begin
                $display("txn H pc=%h acc=%h retired=%0d", addr_to_pm, data_to_dm, retired);
                pop_exp(K_H, e, ok);
                if (ok) begin
                    check("halt_pc", 32'(addr_to_pm), e.a);
                    check("halt_acc", 32'(data_to_dm), e.b);
                    check("halt_retired", retired, e.c);
                    check("halt_no_req", {30'd0, RdRam, WrRam}, 32'd0);
                end
            end
            halted_prev = halted;
        end
    end

    always @(posedge reset) begin : rst_mon
        exp_t e;
        bit   ok;
        #1;
        $display("txn RST pc=%h acc=%h rd=%b wr=%b", addr_to_pm, data_to_dm, RdRam, WrRam);
        pop_exp(K_RST, e, ok);
        if (ok) begin
            check("rst_pc", 32'(addr_to_pm), 32'd0);
            check("rst_acc", 32'(data_to_dm), 32'd0);
            check("rst_dm_addr", 32'(addr_to_dm), 32'd0);
            check("rst_rd", 32'(RdRam), 32'd0);
            check("rst_wr", 32'(WrRam), 32'd0);
            check("rst_halted", 32'(halted), 32'd0);
            check("rst_retired", retired, 32'd0);
        end
    end

    task automatic clear_pm();
        for (int i = 0; i < 2048; i++) pm[i] = enc(OP_HLT, 11'd0);
    endtask

    task automatic poke(input logic [10:0] a, input logic [15:0] d);
        tb_addr = a; tb_data = d; tb_we = 1'b1;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic start_reset();
        push(K_RST, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        clear_pm();
    endtask

    task automatic finish_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_until_halt(input string name);
        int n = 0;
        while (!halted && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_halted"}, 32'(halted), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2;
        // 1: immediate arithmetic and store, no wait states
        start_reset();
        pm[0] = enc(OP_LDI, 11'd5);
        pm[1] = enc(OP_ADDI, 11'h7FD);
        pm[2] = enc(OP_STO, 11'h010);
        pm[3] = enc(OP_HLT, 11'd0);
        dm_wait = 0; pm_rand = 1'b0;
        push(K_W, 32'h010, 32'h0002, 0);
        push(K_H, 32'd3, 32'h0002, 32'd4);
        finish_reset();
        run_until_halt("t1");

        // 2: load with three dm wait cycles
        start_reset();
        poke(11'h020, 16'h1234);
        pm[0] = enc(OP_LD, 11'h020);
        pm[1] = enc(OP_STO, 11'h021);
        pm[2] = enc(OP_HLT, 11'd0);
        dm_wait = 3;
        push(K_R, 32'h020, 32'h1234, 32'd4);
        push(K_W, 32'h021, 32'h1234, 0);
        push(K_H, 32'd2, 32'h1234, 32'd3);
        finish_reset();
        run_until_halt("t2");

        // 3: taken BEQ then taken BNE, random pm wait states
        start_reset();
        pm[0]     = enc(OP_LDI, 11'd0);
        pm[1]     = enc(OP_BEQ, 11'h100);
        pm[11'h100] = enc(OP_LDI, 11'd1);
        pm[11'h101] = enc(OP_BNE, 11'h200);
        pm[11'h200] = enc(OP_HLT, 11'd0);
        dm_wait = 0; pm_rand = 1'b1;
        push(K_H, 32'h200, 32'h0001, 32'd5);
        finish_reset();
        run_until_halt("t3");

        // 4: PC wrap from 0x7FF, sign-extended 0x7FF, modulo add back to zero
        start_reset();
        pm[0] = enc(OP_BNE, 11'd3);
        pm[1] = enc(OP_LDI, 11'd1);
        pm[2] = enc(OP_JMP, 11'h7FF);
        pm[11'h7FF] = enc(5'b11111, 11'd0);
        pm[3] = enc(OP_LDI, 11'h7FF);
        pm[4] = enc(OP_STO, 11'h031);
        pm[5] = enc(OP_ADDI, 11'd1);
        pm[6] = enc(OP_STO, 11'h030);
        pm[7] = enc(OP_HLT, 11'd0);
        pm_rand = 1'b0;
        push(K_W, 32'h031, 32'hFFFF, 0);
        push(K_W, 32'h030, 32'h0000, 0);
        push(K_H, 32'd7, 32'h0000, 32'd10);
        finish_reset();
        run_until_halt("t4");

        // 5: asynchronous reset while a store waits on dm_ready
        start_reset();
        poke(11'h040, 16'hBEEF);
        pm[0] = enc(OP_LDI, 11'd7);
        pm[1] = enc(OP_STO, 11'h040);
        dm_wait = 10;
        finish_reset();
        begin
            int n = 0;
            while (!WrRam && n < 100) begin @(posedge clk); n++; end
        end
        check("t5_wr_request", 32'(WrRam), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #2;
        push(K_RST, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        clear_pm();
        dm_wait = 0;
        push(K_H, 32'd0, 32'd0, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        run_until_halt("t5");
        check("t5_store_aborted", 32'(dm[11'h040]), 32'h0000BEEF);

        // 6: logic/shift program, NOPs when the option is absent
`ifdef BIP_LOGIC_OPS_EN
        exp6 = 16'h00F3;
`else
        exp6 = 16'h000F;
`endif
        start_reset();
        pm[0] = enc(OP_LDI, 11'h00F);
        pm[1] = enc(5'b10010, 11'd4);
        pm[2] = enc(5'b01111, 11'd3);
        pm[3] = enc(OP_STO, 11'h050);
        pm[4] = enc(OP_HLT, 11'd0);
        push(K_W, 32'h050, 32'(exp6), 0);
        push(K_H, 32'd4, 32'(exp6), 32'd5);
        finish_reset();
        run_until_halt("t6");

        // 7: memory ADD/SUB with one dm wait cycle and random pm waits
        start_reset();
        poke(11'h060, 16'd100);
        poke(11'h061, 16'd30);
        pm[0] = enc(OP_LDI, 11'd10);
        pm[1] = enc(OP_ADD, 11'h060);
        pm[2] = enc(OP_SUB, 11'h061);
        pm[3] = enc(OP_STO, 11'h062);
        pm[4] = enc(OP_HLT, 11'd0);
        dm_wait = 1; pm_rand = 1'b1;
        push(K_R, 32'h060, 32'd100, 32'd2);
        push(K_R, 32'h061, 32'd30, 32'd2);
        push(K_W, 32'h062, 32'd80, 0);
        push(K_H, 32'd4, 32'd80, 32'd5);
        finish_reset();
        run_until_halt("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
